// File: rtl/ps2_codes_pkg.sv
// Shared PS/2 set-2 scan-code constants and decoder FSM state encoding
// for the keyboard-driven switch selector.
package ps2_codes_pkg;

    localparam logic [7:0] CODE_DIGIT [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
        8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };
    localparam logic [7:0] CODE_ESC   = 8'h76;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        EXT,
        EXT_BREAK
    } ps2_state_e;

    function automatic logic [9:0] digit_onehot(input logic [3:0] d);
        return 10'd1 << d;
    endfunction

endpackage

// File: rtl/ps2_key_select_if.sv
// Byte-stream input and selection outputs of the PS/2 key selector.
interface ps2_key_select_if;

    logic [7:0] ps2_byte;
    logic       ps2_byte_valid;
    logic [9:0] sel;
    logic       key_event;
    logic [3:0] key_code;

    modport master (
        output ps2_byte, ps2_byte_valid,
        input  sel, key_event, key_code
    );

    modport slave (
        input  ps2_byte, ps2_byte_valid,
        output sel, key_event, key_code
    );

endinterface

// File: rtl/ps2_digit_decode.sv
// Combinational lookup from a scan-code byte to a digit index or the Esc key.
module ps2_digit_decode
    import ps2_codes_pkg::*;
(
    input  logic [7:0] code_byte,
    output logic       is_digit,
    output logic [3:0] digit,
    output logic       is_esc
);

    always_comb begin
        is_digit = 1'b0;
        digit    = 4'd0;
        is_esc   = (code_byte == CODE_ESC);
        for (int i = 0; i < 10; i++) begin
            if (code_byte == CODE_DIGIT[i]) begin
                is_digit = 1'b1;
                digit    = 4'(i);
            end
        end
    end

endmodule

// File: rtl/ps2_key_select.sv
// Turns PS/2 digit key presses into a registered 10-bit switch-style selection,
// tracking make/break/extended prefixes with a timeout on dangling prefixes.
module ps2_key_select
    import ps2_codes_pkg::*;
#(
    parameter int TOGGLE_MODE    = 1,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    ps2_key_select_if.slave   bus
);

    localparam int CW = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    ps2_state_e    state, state_n;
    logic [9:0]    sel_q, sel_n;
    logic [9:0]    held_q, held_n;
    logic          event_q, event_n;
    logic [3:0]    code_q, code_n;
    logic [CW-1:0] cnt_q, cnt_n;

    logic          is_digit;
    logic [3:0]    digit;
    logic          is_esc;

    ps2_digit_decode u_decode (
        .code_byte (bus.ps2_byte),
        .is_digit  (is_digit),
        .digit     (digit),
        .is_esc    (is_esc)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A pending prefix ages out after TIMEOUT_CYCLES quiet cycles, but a byte
    // landing on the expiry cycle still belongs to the prefix.
    // key_event fires on every accepted (non-repeat) digit make.
    always_comb begin
        state_n = state;
        sel_n   = sel_q;
        held_n  = held_q;
        event_n = 1'b0;
        code_n  = code_q;
        cnt_n   = cnt_q;

        if (bus.ps2_byte_valid) begin
            cnt_n = '0;
            case (state)
                IDLE: begin
                    if (bus.ps2_byte == CODE_BREAK) begin
                        state_n = BREAK;
                    end else if (bus.ps2_byte == CODE_EXT) begin
                        state_n = EXT;
                    end else if (is_digit && !held_q[digit]) begin
                        held_n[digit] = 1'b1;
                        sel_n   = (TOGGLE_MODE != 0) ? (sel_q ^ digit_onehot(digit))
                                                     : digit_onehot(digit);
                        event_n = 1'b1;
                        code_n  = digit;
                    end else if (is_esc) begin
                        sel_n = '0;
                    end
                end
                BREAK: begin
                    if (is_digit) begin
                        held_n[digit] = 1'b0;
                    end
                    state_n = IDLE;
                end
                EXT: begin
                    state_n = (bus.ps2_byte == CODE_BREAK) ? EXT_BREAK : IDLE;
                end
                EXT_BREAK: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end else if (state != IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt_q + 1'b1;
            end
        end else begin
            cnt_n = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            sel_q   <= '0;
            held_q  <= '0;
            event_q <= 1'b0;
            code_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sel_q   <= sel_n;
            held_q  <= held_n;
            event_q <= event_n;
            code_q  <= code_n;
            cnt_q   <= cnt_n;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.key_event = event_q;
    assign bus.key_code  = code_q;

endmodule

// File: tb/tb_ps2_key_select.sv
// Scoreboard bench for ps2_key_select: one toggle-mode and one one-hot-mode
// instance share the same byte stream and are checked against a reference model.
module tb_ps2_key_select;

    localparam int T = 16;

    typedef struct {
        logic [9:0] sel_t;
        logic [9:0] sel_o;
        logic       ev;
        logic [3:0] code;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] ps2_byte;
    logic       ps2_valid;

    int checks   = 0;
    int failures = 0;
    int ev_cnt_t = 0;

    exp_t q[$];
    exp_t last = '{sel_t: '0, sel_o: '0, ev: 1'b0, code: '0};
    logic samp_rst  = 1'b0;
    logic samp_byte = 1'b0;

    // reference model state
    int         dcode [10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
    int         pend;
    int         idle_since;
    bit  [9:0]  held_m;
    logic [9:0] sel_tm, sel_om;
    logic [3:0] code_m;

    always #5 clk = ~clk;

    ps2_key_select_if bus_t ();
    ps2_key_select_if bus_o ();

    assign bus_t.ps2_byte       = ps2_byte;
    assign bus_t.ps2_byte_valid = ps2_valid;
    assign bus_o.ps2_byte       = ps2_byte;
    assign bus_o.ps2_byte_valid = ps2_valid;

    ps2_key_select #(.TOGGLE_MODE(1), .TIMEOUT_CYCLES(T)) dut_t (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus_t.slave)
    );

    ps2_key_select #(.TOGGLE_MODE(0), .TIMEOUT_CYCLES(T)) dut_o (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus_o.slave)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int digitOf(input logic [7:0] b);
        for (int i = 0; i < 10; i++) begin
            if (int'(b) == dcode[i]) return i;
        end
        return -1;
    endfunction

    // pend: 0 none, 1 after F0, 2 after E0, 3 after E0 F0
    task automatic modelByte(input logic [7:0] b);
        exp_t e;
        int d;
        d = digitOf(b);
        e.ev = 1'b0;
        if (pend != 0 && idle_since >= T) pend = 0;
        case (pend)
            0: begin
                if (b == 8'hF0) pend = 1;
                else if (b == 8'hE0) pend = 2;
                else if (d >= 0 && !held_m[d]) begin
                    held_m[d] = 1'b1;
                    sel_tm = sel_tm ^ (10'd1 << d);
                    sel_om = 10'd1 << d;
                    code_m = 4'(d);
                    e.ev   = 1'b1;
                end else if (b == 8'h76) begin
                    sel_tm = '0;
                    sel_om = '0;
                end
            end
            1: begin
                if (d >= 0) held_m[d] = 1'b0;
                pend = 0;
            end
            2: pend = (b == 8'hF0) ? 3 : 0;
            default: pend = 0;
        endcase
        idle_since = 0;
        e.sel_t = sel_tm;
        e.sel_o = sel_om;
        e.code  = code_m;
        q.push_back(e);
    endtask

    task automatic modelReset();
        pend = 0;
        idle_since = 0;
        held_m = '0;
        sel_tm = '0;
        sel_om = '0;
        code_m = '0;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        ps2_byte  = b;
        ps2_valid = 1'b1;
        modelByte(b);
        @(posedge clk);
        #2;
        ps2_valid = 1'b0;
        ps2_byte  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            idle_since++;
        end
    endtask

    task automatic doReset(input bit with_valid);
        resetn = 1'b0;
        if (with_valid) begin
            ps2_byte  = 8'h16;
            ps2_valid = 1'b1;
        end
        @(posedge clk);
        #2;
        resetn    = 1'b1;
        ps2_valid = 1'b0;
        modelReset();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        samp_rst  <= !resetn;
        samp_byte <= resetn && ps2_valid;
    end

    always @(negedge clk) begin
        if (bus_t.key_event === 1'b1) ev_cnt_t++;
    end

    // Monitor: pops one expectation per sampled byte; otherwise outputs must hold.
    always @(negedge clk) begin
        if (samp_rst) begin
            last = '{sel_t: '0, sel_o: '0, ev: 1'b0, code: '0};
        end else if (samp_byte) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL sb_underflow: got empty queue expected entry at %0t", $time);
            end else begin
                last = q.pop_front();
            end
        end else begin
            last.ev = 1'b0;
        end
        checkOutput("sel_toggle",  bus_t.sel,       last.sel_t);
        checkOutput("sel_onehot",  bus_o.sel,       last.sel_o);
        checkOutput("event_tog",   bus_t.key_event, last.ev);
        checkOutput("event_one",   bus_o.key_event, last.ev);
        checkOutput("code_tog",    bus_t.key_code,  last.code);
        checkOutput("code_one",    bus_o.key_code,  last.code);
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish by 5ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ev_base;
        int r;
        logic [7:0] b;
        resetn    = 1'b0;
        ps2_valid = 1'b0;
        ps2_byte  = 8'h00;
        modelReset();
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b1;
        settle();
        checkOutput("reset_sel", bus_t.sel, 10'h000);
        checkOutput("reset_code", bus_t.key_code, 4'd0);

        // single make, then release leaves selection alone
        applyStimulus(8'h16);
        settle();
        checkOutput("make1_sel", bus_t.sel, 10'h002);
        checkOutput("make1_code", bus_t.key_code, 4'd1);
        applyStimulus(8'hF0);
        applyStimulus(8'h16);
        settle();
        checkOutput("release1_sel", bus_t.sel, 10'h002);

        // toggle twice
        doReset(1'b0);
        ev_base = ev_cnt_t;
        applyStimulus(8'h16);
        applyStimulus(8'hF0);
        applyStimulus(8'h16);
        applyStimulus(8'h16);
        settle();
        checkOutput("toggle_sel", bus_t.sel, 10'h000);
        checkOutput("toggle_events", ev_cnt_t - ev_base, 2);

        // typematic repeats
        doReset(1'b0);
        ev_base = ev_cnt_t;
        applyStimulus(8'h1E);
        applyStimulus(8'h1E);
        applyStimulus(8'h1E);
        applyStimulus(8'hF0);
        applyStimulus(8'h1E);
        settle();
        checkOutput("typematic_sel", bus_t.sel, 10'h004);
        checkOutput("typematic_events", ev_cnt_t - ev_base, 1);

        // one-hot mode and Esc
        doReset(1'b0);
        applyStimulus(8'h45);
        settle();
        checkOutput("onehot_0", bus_o.sel, 10'h001);
        applyStimulus(8'h46);
        settle();
        checkOutput("onehot_9", bus_o.sel, 10'h200);
        applyStimulus(8'h76);
        settle();
        checkOutput("esc_sel", bus_o.sel, 10'h000);
        checkOutput("esc_event", bus_o.key_event, 1'b0);

        // extended code discarded; prefix timeout exactly at the limit
        doReset(1'b0);
        applyStimulus(8'hE0);
        applyStimulus(8'h16);
        settle();
        checkOutput("ext_sel", bus_t.sel, 10'h000);
        applyStimulus(8'hF0);
        idle(T);
        applyStimulus(8'h16);
        settle();
        checkOutput("timeout_sel", bus_t.sel, 10'h002);

        // one cycle short of the timeout the prefix still applies
        doReset(1'b0);
        applyStimulus(8'h16);
        applyStimulus(8'hF0);
        idle(T - 1);
        applyStimulus(8'h16);
        applyStimulus(8'h16);
        settle();
        checkOutput("pre_timeout_sel", bus_t.sel, 10'h000);

        // reset mid-prefix, with a strobe during the reset cycle
        doReset(1'b0);
        applyStimulus(8'hF0);
        doReset(1'b1);
        applyStimulus(8'h25);
        settle();
        checkOutput("midreset_sel", bus_t.sel, 10'h010);
        checkOutput("midreset_code", bus_t.key_code, 4'd4);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 19);
            if (r < 8) begin
                b = 8'(dcode[$urandom_range(0, (r < 5) ? 3 : 9)]);
                applyStimulus(b);
            end else if (r < 11) begin
                applyStimulus(8'hF0);
            end else if (r < 13) begin
                applyStimulus(8'hE0);
            end else if (r == 13) begin
                applyStimulus(8'h76);
            end else if (r == 14) begin
                applyStimulus(8'($urandom));
            end else if (r < 19) begin
                case ($urandom_range(0, 5))
                    0: idle(T - 1);
                    1: idle(T);
                    2: idle(T + 1);
                    default: idle($urandom_range(1, 3));
                endcase
            end else begin
                if ($urandom_range(0, 3) == 0) doReset(1'($urandom));
                else idle(1);
            end
        end

        idle(3);
        settle();
        checkOutput("sb_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
